gshare_branch_target_buffer: RTL
================================

# gshare_branch_target_buffer

Parametrised fetch-stage predictor for the 5-stage RISC-V pipeline: a tagged direct-mapped BTB plus a gshare direction predictor (global history register XORed with PC into a table of 2-bit saturating counters). It supplies `next_pc` to the PC register every cycle and raises `is_flush` when the EX-stage resolution disagrees with the path already fetched. The PHT index used at fetch travels through internal IF/ID and ID/EX sideband registers, so the counter updated at resolution is exactly the one consulted at prediction.

## Interface
- ENTRY_BIT, 5, BTB index bits; BTB depth = 2**ENTRY_BIT; tag = pc[31:ENTRY_BIT+2]
- GHR_BIT, 6, global history length; PHT depth = 2**GHR_BIT (1 ≤ GHR_BIT ≤ 30)
- PHT_INIT, 2'b01, counter value after reset
- clk  in  1  rising-edge clock; single clock domain
- reset  in  1  synchronous, active-low (0 = reset, sampled on rising `clk`)
- current_pc  in  32  PC of the instruction being fetched
- IF_ID_pc  in  32  PC held in the IF/ID register
- ID_EX_pc  in  32  PC of the instruction in EX
- EX_pc_plus_imm  in  32  branch/jal target computed in EX
- EX_alu_result  in  32  jalr target computed in EX
- ID_EX_is_branch / ID_EX_is_jal / ID_EX_is_jalr  in  1 each  EX instruction type
- EX_alu_bcond  in  1  branch condition result
- stall  in  1  hazard stall: PC and IF/ID hold, ID/EX takes a bubble
- is_flush  out  1  mispredict; core squashes IF/ID and ID/EX
- next_pc  out  32  value the PC register loads
- pred_taken  out  1  fetch-stage prediction was redirect (debug/perf)

## Operation
- Lookup (combinational): `bi = current_pc[ENTRY_BIT+1:2]`, `hit = valid[bi] && tag[bi] == current_pc[31:ENTRY_BIT+2]`; `pi = current_pc[GHR_BIT+1:2] ^ ghr`. `pred_taken = hit && (!is_br[bi] || pht[pi][1])`; predicted PC = `pred_taken ? target[bi] : current_pc + 4` (mod 2**32).
- Resolution: type priority jal > branch > jalr; none set means no resolution. Actual next: jal → EX_pc_plus_imm; branch → bcond ? EX_pc_plus_imm : ID_EX_pc + 4; jalr → EX_alu_result.
- `is_flush = resolving && IF_ID_pc != actual`. `next_pc = is_flush ? actual : predicted` (flush wins over stall; PC enable is external).
- BTB write (posedge, on resolution): valid=1, tag/index from ID_EX_pc, target = EX_pc_plus_imm (jal, branch) or EX_alu_result (jalr), is_br = branch. Non-control instructions never modify the BTB.
- PHT update (posedge, branch only): counter at ID/EX sideband index saturates +1 if bcond else −1 (11 and 00 hold).
- GHR (posedge, branch only): `ghr <= {ghr[GHR_BIT-2:0], EX_alu_bcond}`; non-speculative.
- Sideband: IF/ID idx <= is_flush ? 0 : stall ? hold : pi. ID/EX idx <= (is_flush || stall) ? 0 : IF/ID idx.

## Timing
- Lookup and flush decision are zero-latency combinational; all table/GHR/sideband state updates on the rising edge after resolution.
- Same-cycle lookup and update of one entry: lookup sees pre-edge contents; no bypass.
- Reset (reset=0 at an edge): all valid=0, is_br=0, tags/targets=0, every PHT counter = PHT_INIT, ghr=0, sideband=0; resolution updates suppressed that edge. Outputs stay combinational: with empty tables and no EX control, next_pc = current_pc+4, is_flush=0, pred_taken=0. Reset mid-operation discards all learned state in one cycle.
- Aliasing: different PCs sharing BTB index evict each other (tag mismatch → miss); PHT aliasing is permitted.
- current_pc = 0xFFFFFFFC with miss → next_pc = 0x00000000.

## Test plan
- Reset, current_pc=0x100, no EX control → next_pc=0x104, is_flush=0, pred_taken=0.
- jal at 0x100 target 0x200 in EX with IF_ID_pc=0x104 → is_flush=1, next_pc=0x200; after edge, fetch 0x100 → next_pc=0x200, pred_taken=1.
- beq at 0x40→0x80 resolved taken 3 times (GHR_BIT=2, PHT_INIT=01) → counters trained, then lookup at 0x40 with matching history predicts 0x80; one not-taken resolution with IF_ID_pc=0x80 → is_flush=1, next_pc=0x44.
- jalr at 0x30, EX_alu_result=0x500, IF_ID_pc=0x500 → is_flush=0; BTB entry updated to 0x500.
- stall=1 for 2 cycles between fetch and EX of a branch → ID/EX sideband index matches fetch-time pi; correct counter updated.
- Entry aliasing 0x100 vs 0x100+4·2**ENTRY_BIT; reset asserted mid-run → next lookup misses, PHT back to PHT_INIT.

Source files
------------

// File: rtl/gshare_branch_target_buffer.sv
// Fetch predictor: tagged direct-mapped BTB plus gshare 2-bit counter table; lookup and flush are combinational.
// Tables, history and the PHT-index sideband update on the rising edge after EX resolution; stall holds the IF/ID index.
module gshare_branch_target_buffer #(
  parameter int         ENTRY_BIT = 5,
  parameter int         GHR_BIT   = 6,
  parameter logic [1:0] PHT_INIT  = 2'b01
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] current_pc,
  input  logic [31:0] IF_ID_pc,
  input  logic [31:0] ID_EX_pc,
  input  logic [31:0] EX_pc_plus_imm,
  input  logic [31:0] EX_alu_result,
  input  logic        ID_EX_is_branch,
  input  logic        ID_EX_is_jal,
  input  logic        ID_EX_is_jalr,
  input  logic        EX_alu_bcond,
  input  logic        stall,
  output logic        is_flush,
  output logic [31:0] next_pc,
  output logic        pred_taken
);

  localparam int BTB_DEPTH = 1 << ENTRY_BIT;
  localparam int PHT_DEPTH = 1 << GHR_BIT;
  localparam int TAG_W     = 30 - ENTRY_BIT;

  typedef logic [ENTRY_BIT-1:0] btb_idx_t;
  typedef logic [GHR_BIT-1:0]   pht_idx_t;
  typedef logic [TAG_W-1:0]     tag_t;

  logic [BTB_DEPTH-1:0] valid_q;
  logic [BTB_DEPTH-1:0] is_br_q;
  tag_t                 tag_q    [BTB_DEPTH];
  logic [31:0]          target_q [BTB_DEPTH];
  logic [1:0]           pht_q    [PHT_DEPTH];
  pht_idx_t             ghr_q;
  pht_idx_t             if_id_idx_q;
  pht_idx_t             id_ex_idx_q;

  btb_idx_t    look_idx;
  tag_t        look_tag;
  pht_idx_t    look_pi;
  logic        look_hit;
  logic [31:0] pred_pc;

  assign look_idx   = current_pc[ENTRY_BIT+1:2];
  assign look_tag   = current_pc[31:ENTRY_BIT+2];
  assign look_pi    = current_pc[GHR_BIT+1:2] ^ ghr_q;
  assign look_hit   = valid_q[look_idx] && (tag_q[look_idx] == look_tag);
  assign pred_taken = look_hit && (!is_br_q[look_idx] || pht_q[look_pi][1]);
  assign pred_pc    = pred_taken ? target_q[look_idx] : current_pc + 32'd4;

  // jal outranks branch, which outranks jalr, when decode flags overlap.
  logic        res_jal;
  logic        res_br;
  logic        res_jalr;
  logic        resolving;
  logic [31:0] actual_pc;
  logic [31:0] res_target;

  always_comb begin
    res_jal    = ID_EX_is_jal;
    res_br     = !ID_EX_is_jal && ID_EX_is_branch;
    res_jalr   = !ID_EX_is_jal && !ID_EX_is_branch && ID_EX_is_jalr;
    resolving  = res_jal || res_br || res_jalr;
    res_target = res_jalr ? EX_alu_result : EX_pc_plus_imm;
    actual_pc  = ID_EX_pc + 32'd4;
    if (res_jal) begin
      actual_pc = EX_pc_plus_imm;
    end else if (res_br) begin
      actual_pc = EX_alu_bcond ? EX_pc_plus_imm : ID_EX_pc + 32'd4;
    end else if (res_jalr) begin
      actual_pc = EX_alu_result;
    end
  end

  assign is_flush = resolving && (IF_ID_pc != actual_pc);
  assign next_pc  = is_flush ? actual_pc : pred_pc;

  btb_idx_t wr_idx;
  tag_t     wr_tag;

  assign wr_idx = ID_EX_pc[ENTRY_BIT+1:2];
  assign wr_tag = ID_EX_pc[31:ENTRY_BIT+2];

  always_ff @(posedge clk) begin
    if (!reset) begin
      valid_q <= '0;
      is_br_q <= '0;
      for (int i = 0; i < BTB_DEPTH; i++) begin
        tag_q[i]    <= '0;
        target_q[i] <= '0;
      end
    end else if (resolving) begin
      valid_q[wr_idx]  <= 1'b1;
      is_br_q[wr_idx]  <= res_br;
      tag_q[wr_idx]    <= wr_tag;
      target_q[wr_idx] <= res_target;
    end
  end

  // Train the counter that was consulted at fetch, carried via the sideband.
  logic [1:0] cnt_cur;
  logic [1:0] cnt_next;

  always_comb begin
    cnt_cur  = pht_q[id_ex_idx_q];
    cnt_next = cnt_cur;
    if (EX_alu_bcond) begin
      if (cnt_cur != 2'b11) cnt_next = cnt_cur + 2'b01;
    end else begin
      if (cnt_cur != 2'b00) cnt_next = cnt_cur - 2'b01;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < PHT_DEPTH; i++) begin
        pht_q[i] <= PHT_INIT;
      end
    end else if (res_br) begin
      pht_q[id_ex_idx_q] <= cnt_next;
    end
  end

  pht_idx_t ghr_next;

  generate
    if (GHR_BIT == 1) begin : g_ghr_one
      assign ghr_next = EX_alu_bcond;
    end else begin : g_ghr_multi
      assign ghr_next = {ghr_q[GHR_BIT-2:0], EX_alu_bcond};
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!reset) begin
      ghr_q       <= '0;
      if_id_idx_q <= '0;
      id_ex_idx_q <= '0;
    end else begin
      if (res_br) ghr_q <= ghr_next;
      if (is_flush) begin
        if_id_idx_q <= '0;
      end else if (!stall) begin
        if_id_idx_q <= look_pi;
      end
      id_ex_idx_q <= (is_flush || stall) ? '0 : if_id_idx_q;
    end
  end

endmodule
